// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: load-op codes, stall-vector bit
// positions and the width of the MEM->WB bundle.
package wb_stage_pkg;

  typedef logic [2:0] load_op_t;

  localparam load_op_t LOAD_NONE = 3'd0;
  localparam load_op_t LOAD_LB   = 3'd1;
  localparam load_op_t LOAD_LBU  = 3'd2;
  localparam load_op_t LOAD_LH   = 3'd3;
  localparam load_op_t LOAD_LHU  = 3'd4;
  localparam load_op_t LOAD_LW   = 3'd5;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam int WB_REG_AW = 5;
  localparam int WB_DW     = 32;
  // valid + pc + we + waddr + result + load_op
  localparam int MEMWB_W   = 1 + WB_DW + 1 + WB_REG_AW + WB_DW + 3;

  function automatic logic is_load(input load_op_t op);
    return (op == LOAD_LB) || (op == LOAD_LBU) || (op == LOAD_LH) ||
           (op == LOAD_LHU) || (op == LOAD_LW);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of the
// SRAM word and extends it; non-loads pass the ALU result through.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    load_op,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] result,
  output logic [DW-1:0] wdata
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word[7:0];
    case (addr_lo)
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      2'd3:    byteSel = word[31:24];
      default: byteSel = word[7:0];
    endcase
    // Halfword misalignment traps upstream, so only addr_lo[1] matters here.
    halfSel = addr_lo[1] ? word[31:16] : word[15:0];

    wdata = result;
    case (load_op)
      LOAD_LB:  wdata = {{(DW-8){byteSel[7]}}, byteSel};
      LOAD_LBU: wdata = {{(DW-8){1'b0}}, byteSel};
      LOAD_LH:  wdata = {{(DW-16){halfSel[15]}}, halfSel};
      LOAD_LHU: wdata = {{(DW-16){1'b0}}, halfSel};
      LOAD_LW:  wdata = word;
      default:  wdata = result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: final pipeline register, load data capture/alignment,
// register-file write port and debug trace outputs.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [DW-1:0]     mem_pc,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DW-1:0]     mem_result,
  input  logic [2:0]        mem_load_op,
  input  logic [DW-1:0]     data_sram_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [DW-1:0]     debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0]     debug_wb_rf_wdata
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic [DW-1:0]     result_q, result_d;
  logic [2:0]        load_op_q, load_op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DW-1:0]     rdata_hold_q, rdata_hold_d;

  logic              stallMem, stallWb;
  logic [DW-1:0]     loadWord;
  logic              stall_unused;

  assign stallMem     = stall[STALL_MEM];
  assign stallWb      = stall[STALL_WB];
  assign stall_unused = ^{stall[5], stall[2:0]};

  // Flush outranks stall; the SRAM word is captured only on the first held
  // edge, since the SRAM output is not guaranteed stable after that.
  always_comb begin
    valid_d      = valid_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    pc_d         = pc_q;
    result_d     = result_q;
    load_op_d    = load_op_q;
    addr_lo_d    = addr_lo_q;
    hold_valid_d = hold_valid_q;
    rdata_hold_d = rdata_hold_q;
    if (flush) begin
      valid_d      = 1'b0;
      we_d         = 1'b0;
      waddr_d      = '0;
      pc_d         = '0;
      result_d     = '0;
      load_op_d    = LOAD_NONE;
      addr_lo_d    = 2'd0;
      hold_valid_d = 1'b0;
    end else if (stallMem && !stallWb) begin
      valid_d      = 1'b0;
      we_d         = 1'b0;
      hold_valid_d = 1'b0;
    end else if (!stallMem) begin
      valid_d      = mem_valid;
      we_d         = mem_we;
      waddr_d      = mem_waddr;
      pc_d         = mem_pc;
      result_d     = mem_result;
      load_op_d    = mem_load_op;
      addr_lo_d    = mem_result[1:0];
      hold_valid_d = 1'b0;
    end else if (valid_q && is_load(load_op_q) && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      rdata_hold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      pc_q         <= '0;
      result_q     <= '0;
      load_op_q    <= LOAD_NONE;
      addr_lo_q    <= 2'd0;
      hold_valid_q <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      valid_q      <= valid_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      pc_q         <= pc_d;
      result_q     <= result_d;
      load_op_q    <= load_op_d;
      addr_lo_q    <= addr_lo_d;
      hold_valid_q <= hold_valid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign loadWord = hold_valid_q ? rdata_hold_q : data_sram_rdata;

  wb_stage_load_align #(
    .DW(DW)
  ) u_align (
    .load_op (load_op_q),
    .addr_lo (addr_lo_q),
    .word    (loadWord),
    .result  (result_q),
    .wdata   (rf_wdata)
  );

  assign rf_we             = valid_q & we_q & (waddr_q != '0);
  assign rf_waddr          = waddr_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = waddr_q;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU writeback, load alignment,
// stall hold/capture, bubbles, $0 suppression, flush and reset.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic [2:0]  mem_load_op;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_stage #(
    .REG_AW(5),
    .DW(32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .mem_valid         (mem_valid),
    .mem_pc            (mem_pc),
    .mem_we            (mem_we),
    .mem_waddr         (mem_waddr),
    .mem_result        (mem_result),
    .mem_load_op       (mem_load_op),
    .data_sram_rdata   (data_sram_rdata),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one MEM bundle plus control, then advance one edge and settle.
  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] wa,
                               input logic [31:0] pc, input logic [31:0] res,
                               input logic [2:0] op, input logic [31:0] rdata,
                               input logic [5:0] stl, input logic fl, input logic rs);
    mem_valid       = v;
    mem_we          = we;
    mem_waddr       = wa;
    mem_pc          = pc;
    mem_result      = res;
    mem_load_op     = op;
    data_sram_rdata = rdata;
    stall           = stl;
    flush           = fl;
    rst             = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 6'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 6'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 6'b0, 1'b0, 1'b0);
    checkOutput("idle_rf_we",    {31'd0, rf_we}, 32'd0);
    checkOutput("idle_wen",      {28'd0, debug_wb_rf_wen}, 32'd0);
    checkOutput("idle_pc",       debug_wb_pc, 32'd0);
    checkOutput("idle_wnum",     {27'd0, debug_wb_rf_wnum}, 32'd0);
    checkOutput("idle_wdata",    debug_wb_rf_wdata, 32'd0);

    // ADDU $3
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hBFC0_0000, 32'h1234_5678, 3'd0, 32'h0, 6'b0, 1'b0, 1'b0);
    checkOutput("addu_we",    {31'd0, rf_we}, 32'd1);
    checkOutput("addu_waddr", {27'd0, rf_waddr}, 32'd3);
    checkOutput("addu_wdata", rf_wdata, 32'h1234_5678);
    checkOutput("addu_wen",   {28'd0, debug_wb_rf_wen}, 32'hF);
    checkOutput("addu_pc",    debug_wb_pc, 32'hBFC0_0000);
    checkOutput("addu_wnum",  {27'd0, debug_wb_rf_wnum}, 32'd3);
    checkOutput("addu_dwdata", debug_wb_rf_wdata, 32'h1234_5678);

    // Alignment from word 0x80FF_7F01
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hBFC0_0004, 32'h0000_1003, 3'd1, 32'h80FF_7F01, 6'b0, 1'b0, 1'b0);
    checkOutput("lb_3",  rf_wdata, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hBFC0_0008, 32'h0000_1003, 3'd2, 32'h80FF_7F01, 6'b0, 1'b0, 1'b0);
    checkOutput("lbu_3", rf_wdata, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hBFC0_000C, 32'h0000_1002, 3'd3, 32'h80FF_7F01, 6'b0, 1'b0, 1'b0);
    checkOutput("lh_2",  rf_wdata, 32'hFFFF_80FF);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hBFC0_0010, 32'h0000_1000, 3'd4, 32'h80FF_7F01, 6'b0, 1'b0, 1'b0);
    checkOutput("lhu_0", rf_wdata, 32'h0000_7F01);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hBFC0_0014, 32'h0000_1001, 3'd1, 32'h80FF_7F01, 6'b0, 1'b0, 1'b0);
    checkOutput("lb_1",  rf_wdata, 32'h0000_007F);

    // LW $5 held for three cycles; SRAM data changes after the first cycle
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hBFC0_0020, 32'h0000_2000, 3'd5, 32'h1122_3344, 6'b0, 1'b0, 1'b0);
    checkOutput("lw_first", rf_wdata, 32'h1122_3344);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'hBFC0_0024, 32'h0000_0077, 3'd0, 32'h1122_3344, 6'b011000, 1'b0, 1'b0);
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("hold1_wdata", rf_wdata, 32'h1122_3344);
    checkOutput("hold1_we",    {31'd0, rf_we}, 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'hBFC0_0024, 32'h0000_0077, 3'd0, 32'hDEAD_BEEF, 6'b011000, 1'b0, 1'b0);
    checkOutput("hold2_wdata", rf_wdata, 32'h1122_3344);
    checkOutput("hold2_pc",    debug_wb_pc, 32'hBFC0_0020);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'hBFC0_0024, 32'h0000_0077, 3'd0, 32'hDEAD_BEEF, 6'b011000, 1'b0, 1'b0);
    checkOutput("hold3_wdata", rf_wdata, 32'h1122_3344);
    checkOutput("hold3_waddr", {27'd0, rf_waddr}, 32'd5);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'hBFC0_0024, 32'h0000_0077, 3'd0, 32'hDEAD_BEEF, 6'b0, 1'b0, 1'b0);
    checkOutput("release_wdata", rf_wdata, 32'h0000_0077);
    checkOutput("release_waddr", {27'd0, rf_waddr}, 32'd6);

    // A load right after a hold must use live SRAM data again
    applyStimulus(1'b1, 1'b1, 5'd7, 32'hBFC0_0028, 32'h0000_2004, 3'd5, 32'hA5A5_5A5A, 6'b0, 1'b0, 1'b0);
    checkOutput("lw_live_after_hold", rf_wdata, 32'hA5A5_5A5A);

    // Bubble: MEM held, WB free
    applyStimulus(1'b1, 1'b1, 5'd8, 32'hBFC0_0030, 32'h0000_0055, 3'd0, 32'h0, 6'b001000, 1'b0, 1'b0);
    checkOutput("bubble_we",  {31'd0, rf_we}, 32'd0);
    checkOutput("bubble_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd8, 32'hBFC0_0030, 32'h0000_0055, 3'd0, 32'h0, 6'b0, 1'b0, 1'b0);
    checkOutput("after_bubble_we",    {31'd0, rf_we}, 32'd1);
    checkOutput("after_bubble_waddr", {27'd0, rf_waddr}, 32'd8);
    checkOutput("after_bubble_wdata", rf_wdata, 32'h0000_0055);

    // Write to $0 is suppressed
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hBFC0_0034, 32'hFFFF_FFFF, 3'd0, 32'h0, 6'b0, 1'b0, 1'b0);
    checkOutput("zero_reg_we", {31'd0, rf_we}, 32'd0);
    // mem_we=0 is suppressed
    applyStimulus(1'b1, 1'b0, 5'd9, 32'hBFC0_0038, 32'h0000_0001, 3'd0, 32'h0, 6'b0, 1'b0, 1'b0);
    checkOutput("no_we", {31'd0, rf_we}, 32'd0);

    // Flush while a valid load sits in WB
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0100, 32'h0000_3000, 3'd5, 32'h0BAD_F00D, 6'b0, 1'b0, 1'b0);
    checkOutput("pre_flush_wdata", rf_wdata, 32'h0BAD_F00D);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0104, 32'h0000_3000, 3'd5, 32'h0BAD_F00D, 6'b011000, 1'b1, 1'b0);
    checkOutput("flush_we", {31'd0, rf_we}, 32'd0);
    checkOutput("flush_pc", debug_wb_pc, 32'd0);

    // Reset in the middle of a hold
    applyStimulus(1'b1, 1'b1, 5'd10, 32'hBFC0_0040, 32'h0000_4000, 3'd5, 32'hCAFE_BABE, 6'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd10, 32'hBFC0_0040, 32'h0000_4000, 3'd5, 32'hCAFE_BABE, 6'b011000, 1'b0, 1'b0);
    data_sram_rdata = 32'h9999_9999;
    #1;
    checkOutput("pre_rst_hold", rf_wdata, 32'hCAFE_BABE);
    applyStimulus(1'b1, 1'b1, 5'd10, 32'hBFC0_0040, 32'h0000_4000, 3'd5, 32'h9999_9999, 6'b011000, 1'b1, 1'b1);
    checkOutput("rst_we",    {31'd0, rf_we}, 32'd0);
    checkOutput("rst_wdata", rf_wdata, 32'd0);
    checkOutput("rst_pc",    debug_wb_pc, 32'd0);
    checkOutput("rst_wnum",  {27'd0, debug_wb_rf_wnum}, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd11, 32'hBFC0_0044, 32'h0000_4004, 3'd5, 32'h1357_9BDF, 6'b0, 1'b0, 1'b0);
    checkOutput("post_rst_live", rf_wdata, 32'h1357_9BDF);
    checkOutput("post_rst_waddr", {27'd0, rf_waddr}, 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage pipeline: the writer side of the register file.
- Latches the MEM→WB bundle and aligns and extends load data from the synchronous data SRAM.
- Drives the register-file write port (we/waddr/wdata), which also serves as the WB forwarding source.
- Drives the debug trace interface. It is the final pipeline register; nothing is downstream of it.

Parameters:
- REG_AW, 5, register address width
- DW, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; stall[3]=MEM held, stall[4]=WB held
- flush  in  1  exception flush; kills the WB entry
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_pc  in  DW  PC of the MEM instruction
- mem_we  in  1  instruction writes a GPR
- mem_waddr  in  REG_AW  destination register
- mem_result  in  DW  ALU/move result; for loads, the effective address
- mem_load_op  in  3  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW (others = none)
- data_sram_rdata  in  DW  SRAM read data, valid in the first cycle the load occupies WB
- rf_we  out  1  register-file write enable (also the WB forwarding enable)
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DW  write data
- debug_wb_pc  out  DW  trace PC
- debug_wb_rf_wen  out  4  trace byte-enable, {4{rf_we}}
- debug_wb_rf_wnum  out  REG_AW  trace register number
- debug_wb_rf_wdata  out  DW  trace data

Behaviour:
- Pipeline register, per clk edge:
  - rst=1 or flush=1: clear all fields (valid=0, we=0, waddr=0, pc=0, result=0, load_op=0, addr_lo=0) and clear hold_valid.
  - Else stall[3]=1 and stall[4]=0: insert a bubble (valid=0, we=0).
  - Else stall[3]=0: load the MEM bundle; addr_lo is taken from mem_result[1:0].
  - Else (stall[3]=1 and stall[4]=1): hold all fields.
- SRAM data capture:
  - data_sram_rdata is trusted only in the first WB cycle.
  - On any edge where the register holds (stall[4]=1), a valid load in WB with hold_valid=0 sets hold_valid=1 and rdata_hold=data_sram_rdata.
  - Data source: rdata_hold when hold_valid=1, else data_sram_rdata.
  - hold_valid clears on the next non-hold update (a new load or a bubble) and on rst/flush.
- Load alignment, combinational from the latched fields:
  - LB/LBU: byte addr_lo, sign-/zero-extended.
  - LH/LHU: halfword addr_lo[1] (0 = [15:0], 1 = [31:16]); addr_lo[0] is ignored because misalignment is trapped upstream.
  - LW: full word.
  - none: rf_wdata = latched result.
- Outputs:
  - rf_we = valid & we & (waddr≠0).
  - rf_waddr and rf_wdata come from the latched fields; outputs are asserted in the same cycle the entry sits in WB.
  - Register-file write latency is 1 edge after the entry enters WB.
  - Debug outputs mirror the rf_* outputs; debug_wb_pc = latched pc and is held during stalls.
  - Because the rf_we term is still asserted during a stall, the register-file rewrites the same value each held cycle, which is benign.
- Reset values: every output is 0.
- Simultaneous events:
  - rst beats flush, which beats stall.
  - A flush during a hold discards the held entry and the capture.
- Write-after-write to the same register across consecutive instructions is handled naturally: each writes in its own WB cycle.

Decomposition:
- Shared defines header: load-op encodings (LOAD_NONE..LOAD_LW), stall-vector bit indices, and the MEM→WB bus width.
- Natural sub-module: load_align (combinational; inputs load_op, addr_lo, word, result; output wdata). It is reusable by the MEM-stage forwarding path.

Test Plan:
- Reset then idle → rf_we=0, all debug outputs 0; an ADDU to $3 with result 0x1234_5678 → one cycle later rf_we=1, waddr=3, wdata=0x12345678, debug_wb_rf_wen=4'hF.
- Loads from word 0x80FF_7F01:
  - LB with addr_lo=3 → wdata 0xFFFFFF80.
  - LBU with addr_lo=3 → wdata 0x00000080.
  - LH with addr_lo=2 → wdata 0xFFFF80FF.
  - LHU with addr_lo=0 → wdata 0x00007F01.
- Load LW held with stall[4]=1 for 3 cycles while data_sram_rdata changes to 0xDEADBEEF after the first cycle → rf_wdata stays at the first-cycle value 0x11223344 throughout.
- stall[3]=1 and stall[4]=0 → the next cycle shows a bubble, rf_we=0; the instruction enters WB once stall[3] drops.
- Write to $0 with mem_we=1 → rf_we=0; flush while a valid load sits in WB → the next cycle gives rf_we=0 and debug_wb_pc=0.
- rst asserted mid-hold → all outputs 0 next cycle, hold_valid cleared; the following load uses live SRAM data.
